// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one off-chip memory port between the icache and dcache
// refill paths. Grants one requester at a time and carries one transaction
// (read line fill or dcache write-back) through request, write-data and
// response phases, steering response beats back to the owner.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise the dcache always wins a tie (fixed priority, no pointer).
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   ic_req_*                icache read request / grant pulse
//   ic_resp_valid           response beat belongs to icache
//   dc_req_*                dcache request (rw: 1 = write-back) / grant pulse
//   dc_wdata_*              dcache write beats (passthrough to memory)
//   dc_resp_valid           response beat belongs to dcache
//   resp_data, resp_last    shared response data / last-beat flag
//   mem_req_*               latched request to memory
//   mem_wdata_*             write beats to memory
//   mem_resp_*              read beats from memory
//   busy, owner             transaction in flight / 0 = icache, 1 = dcache
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                owner_q, owner_d;

  logic prefer_dc;
  logic pick_dc;
  logic grant;
  logic cnt_last;
  logic req_hs;
  logic wbeat;
  logic rbeat;

`ifdef MEM_ARB_RR_EN
  // Tie-break pointer: 1 = dcache favoured; flips to the other side on each grant.
  logic rr_prefer_dc_q, rr_prefer_dc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_prefer_dc_q <= 1'b1;
    else        rr_prefer_dc_q <= rr_prefer_dc_d;
  end

  always_comb begin
    rr_prefer_dc_d = rr_prefer_dc_q;
    if (grant) rr_prefer_dc_d = ~pick_dc;
  end

  assign prefer_dc = rr_prefer_dc_q;
`else
  assign prefer_dc = 1'b1;
`endif

  // Winner selection; grant is gated by reset so no ready leaks while held in reset.
  assign pick_dc  = dc_req_valid & (~ic_req_valid | prefer_dc);
  assign grant    = reset & (state_q == ST_IDLE) & (ic_req_valid | dc_req_valid);
  assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));
  assign req_hs   = (state_q == ST_REQ) & mem_req_ready;
  assign wbeat    = (state_q == ST_WDATA) & dc_wdata_valid & mem_wdata_ready;
  assign rbeat    = (state_q == ST_RDATA) & mem_resp_valid;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_REQ;
      ST_REQ:   if (mem_req_ready) state_d = rw_q ? ST_WDATA : ST_RDATA;
      ST_WDATA: if (wbeat && cnt_last) state_d = ST_IDLE;
      ST_RDATA: if (rbeat && cnt_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: grant pulses and zero-latency data-phase steering.
  always_comb begin
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;
    resp_last       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ic_req_ready = grant & ~pick_dc;
        dc_req_ready = grant & pick_dc;
      end
      ST_REQ: mem_req_valid = 1'b1;
      ST_WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
      end
      ST_RDATA: begin
        ic_resp_valid = mem_resp_valid & ~owner_q;
        dc_resp_valid = mem_resp_valid & owner_q;
        resp_last     = mem_resp_valid & cnt_last;
      end
      default: ;
    endcase
  end

  // Transaction context captured at grant; beat counter wraps on the last beat.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    owner_d = owner_q;
    if (grant) begin
      owner_d = pick_dc;
      addr_d  = pick_dc ? dc_req_addr : ic_req_addr;
      rw_d    = pick_dc & dc_req_rw;
    end
    if (req_hs) cnt_d = '0;
    else if (wbeat || rbeat) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      owner_q <= owner_d;
    end
  end

  assign mem_req_addr = addr_q;
  assign mem_req_rw   = rw_q;
  assign mem_wdata    = dc_wdata;
  assign resp_data    = mem_resp_data;
  assign busy         = (state_q != ST_IDLE);
  assign owner        = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, memory
// requests, write beats and response beats; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BEATS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy, owner;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr),
    .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid),
    .resp_data(resp_data), .resp_last(resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .owner(owner)
  );

  typedef struct packed {
    logic              dc;
    logic              last;
    logic [DATA_W-1:0] data;
  } resp_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } mreq_t;

  int checks = 0;
  int errors = 0;

  logic              exp_grant_q[$];
  mreq_t             exp_mreq_q[$];
  logic [DATA_W-1:0] exp_wdata_q[$];
  resp_t             exp_resp_q[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT-side handshake must match the head of its queue.
  logic  m_eg;
  mreq_t m_em;
  logic [DATA_W-1:0] m_ew;
  resp_t m_er;

  always @(negedge clk) begin
    if (reset) begin
      if (ic_req_ready || dc_req_ready) begin
        if (exp_grant_q.size() == 0) chk("unexpected_grant", {ic_req_ready, dc_req_ready}, 0);
        else begin
          m_eg = exp_grant_q.pop_front();
          chk("grant_both", ic_req_ready & dc_req_ready, 0);
          chk("grant_dc", dc_req_ready, m_eg);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mreq_q.size() == 0) chk("unexpected_mem_req", mem_req_valid, 0);
        else begin
          m_em = exp_mreq_q.pop_front();
          chk("mem_req_addr", mem_req_addr, m_em.addr);
          chk("mem_req_rw", mem_req_rw, m_em.rw);
        end
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        if (exp_wdata_q.size() == 0) chk("unexpected_wbeat", mem_wdata_valid, 0);
        else begin
          m_ew = exp_wdata_q.pop_front();
          chk("mem_wdata", mem_wdata, m_ew);
        end
      end
      if (ic_resp_valid || dc_resp_valid) begin
        if (exp_resp_q.size() == 0) chk("unexpected_resp", {ic_resp_valid, dc_resp_valid}, 0);
        else begin
          m_er = exp_resp_q.pop_front();
          chk("resp_owner", {ic_resp_valid, dc_resp_valid}, {~m_er.dc, m_er.dc});
          chk("resp_data", resp_data, m_er.data);
          chk("resp_last", resp_last, m_er.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant pulse in the current IDLE cycle.
  task automatic wait_grant(input string name);
    int n = 0;
    #1;
    while (!(ic_req_ready || dc_req_ready) && n < 20) begin
      step();
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 20 cycles, actual 0 required 1", name);
    end
  endtask

  task automatic mem_req_hs();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic read_beats(input logic [DATA_W-1:0] base, input int gap, input int nb);
    for (int b = 0; b < nb; b++) begin
      repeat (gap) step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + DATA_W'(b);
      step();
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic push_read(input logic dc, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] base, input int nb);
    exp_grant_q.push_back(dc);
    exp_mreq_q.push_back('{rw: 1'b0, addr: addr});
    for (int b = 0; b < nb; b++)
      exp_resp_q.push_back('{dc: dc, last: (b == BEATS - 1), data: base + DATA_W'(b)});
  endtask

  logic win_tbl [5];
  logic [DATA_W-1:0] wd [4];
  logic [DATA_W-1:0] base;
  logic acc;
  int k, cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef MEM_ARB_RR_EN
    win_tbl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    win_tbl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 28'h1234567;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h7654321;
    dc_wdata_valid = 1'b0; dc_wdata = '0;
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state, with both requesters asserting.
    repeat (3) step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ic_req_ready", ic_req_ready, 0);
    chk("rst_dc_req_ready", dc_req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_rw", mem_req_rw, 0);
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_rw = 1'b0;
    step();
    reset = 1'b1;

    // Spurious memory response while idle.
    mem_resp_valid = 1'b1; mem_resp_data = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_spurious_resp", {ic_resp_valid, dc_resp_valid, resp_last}, 0);
      chk("idle_busy", busy, 0);
      step();
    end
    mem_resp_valid = 1'b0;

    // Ties held back-to-back, then dcache drops out.
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000AAA;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0000DDD;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) dc_req_valid = 1'b0;
      base = DATA_W'(32'h3000_0000) + DATA_W'(t * 16);
      push_read(win_tbl[t], win_tbl[t] ? 28'h0000DDD : 28'h0000AAA, base, BEATS);
      wait_grant("tie_grant");
      step();
      mem_req_hs();
      read_beats(base, 0, BEATS);
    end
    ic_req_valid = 1'b0;

    // Lone icache read with 2-cycle gaps between beats.
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000123;
    push_read(1'b0, 28'h0000123, 128'hA0, BEATS);
    wait_grant("ic_read_grant");
    step();
    ic_req_valid = 1'b0;
    #1;
    chk("ic_read_req_valid", mem_req_valid, 1);
    mem_req_hs();
    read_beats(128'hA0, 2, BEATS);
    #1;
    chk("ic_read_idle_after", busy, 0);

    // Dcache write-back, toggling memory ready, spurious responses during WDATA.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000 + DATA_W'(i);
      exp_wdata_q.push_back(wd[i]);
    end
    exp_grant_q.push_back(1'b1);
    exp_mreq_q.push_back('{rw: 1'b1, addr: 28'hABCDEF0});
    step();
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'hABCDEF0;
    wait_grant("wb_grant");
    step();
    dc_req_valid = 1'b0; dc_req_rw = 1'b0;
    mem_req_hs();
    k = 0; cyc = 0;
    dc_wdata_valid = 1'b1;
    while (k < 4 && cyc < 40) begin
      mem_wdata_ready = cyc[0];
      dc_wdata = wd[k];
      mem_resp_valid = 1'b1; mem_resp_data = '1;
      #1;
      chk("wb_spurious_resp", {ic_resp_valid, dc_resp_valid}, 0);
      chk("wb_busy", busy, 1);
      chk("wb_wready_pass", dc_wdata_ready, mem_wdata_ready);
      acc = mem_wdata_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    chk("wb_beats", k, 4);
    #1;
    chk("wb_busy_drop", busy, 0);
    dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;

    // Memory stalls the request for 10 cycles while dcache waits.
    ic_req_valid = 1'b1; ic_req_addr = 28'h5555555;
    push_read(1'b0, 28'h5555555, 128'h5000, BEATS);
    wait_grant("stall_grant");
    step();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h1111111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, 28'h5555555);
      chk("stall_req_rw", mem_req_rw, 0);
      chk("stall_no_ready", {ic_req_ready, dc_req_ready}, 0);
      step();
    end
    dc_req_valid = 1'b0; dc_req_rw = 1'b0;
    mem_req_hs();
    read_beats(128'h5000, 1, BEATS);

    // Reset asserted during read beat 2.
    ic_req_valid = 1'b1; ic_req_addr = 28'h0ABC000;
    push_read(1'b0, 28'h0ABC000, 128'h7000, 2);
    wait_grant("rst_mid_grant");
    step();
    ic_req_valid = 1'b0;
    mem_req_hs();
    read_beats(128'h7000, 0, 2);
    mem_resp_valid = 1'b1; mem_resp_data = 128'h7002;
    ic_req_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_mid_resp", {ic_resp_valid, dc_resp_valid, resp_last}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", {ic_req_ready, dc_req_ready}, 0);
    chk("rst_mid_owner_addr", {owner, mem_req_addr}, 0);
    step();
    ic_req_valid = 1'b0; mem_resp_valid = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Fresh icache read after reset: counter restarts at 0.
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000077;
    push_read(1'b0, 28'h0000077, 128'h9000, BEATS);
    wait_grant("post_rst_grant");
    step();
    ic_req_valid = 1'b0;
    mem_req_hs();
    read_beats(128'h9000, 1, BEATS);
    #1;
    chk("post_rst_idle", busy, 0);

    repeat (2) step();
    chk("left_grant", exp_grant_q.size(), 0);
    chk("left_mreq", exp_mreq_q.size(), 0);
    chk("left_wdata", exp_wdata_q.size(), 0);
    chk("left_resp", exp_resp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares the single off-chip memory request/data/response port between the instruction-cache and data-cache refill paths of the Riscv151 core. It grants one requester at a time and carries one memory transaction at a time: a read line fill or a data-cache write-back. It sequences the request, write-data and response phases, and steers response beats back to the owner. It sits between the two cache controllers and the memory model.

## Interface
- ADDR_W, 28, memory line address width
- DATA_W, 128, beat width
- BEATS, 4, beats per line (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  icache read request
- ic_req_ready  out  1  icache request accepted (grant pulse)
- ic_req_addr  in  ADDR_W  icache line address
- ic_resp_valid  out  1  response beat for icache
- dc_req_valid  in  1  dcache request
- dc_req_ready  out  1  dcache request accepted (grant pulse)
- dc_req_rw  in  1  1 = write-back, 0 = read
- dc_req_addr  in  ADDR_W  dcache line address
- dc_wdata_valid  in  1  dcache write beat valid
- dc_wdata_ready  out  1  write beat accepted
- dc_wdata  in  DATA_W  write beat
- dc_resp_valid  out  1  response beat for dcache
- resp_data  out  DATA_W  shared response data (mem_resp_data passthrough)
- resp_last  out  1  current response beat is beat BEATS-1
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  latched rw
- mem_req_addr  out  ADDR_W  latched address
- mem_wdata_valid  out  1  write beat to memory
- mem_wdata_ready  in  1  memory accepts beat
- mem_wdata  out  DATA_W  dc_wdata passthrough
- mem_resp_valid  in  1  read beat from memory
- mem_resp_data  in  DATA_W  read beat data
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = icache, 1 = dcache (valid while busy)

## Operation
- States: IDLE, REQ, WDATA, RDATA.
- IDLE: if any req_valid, pick a winner and assert its req_ready for exactly that cycle. Latch addr, rw (icache ⇒ rw=0) and owner. Next state is REQ.
- REQ: mem_req_valid=1 with latched addr/rw, held stable until mem_req_ready. On handshake, go to WDATA if rw=1, else RDATA. Beat counter is cleared.
- WDATA: mem_wdata_valid=dc_wdata_valid; dc_wdata_ready=mem_wdata_ready (combinational). Counter increments per accepted beat. The beat at counter BEATS-1 returns the block to IDLE. No memory response is expected for writes.
- RDATA: ic_resp_valid/dc_resp_valid = mem_resp_valid gated by owner. Counter increments per beat. resp_last=1 when counter=BEATS-1; that beat returns the block to IDLE.
- mem_resp_valid outside RDATA is ignored: no resp_valid is produced.
- Counter width is log2(BEATS). It wraps to 0 on the last beat.
- req_ready is never asserted outside IDLE. A requester holding valid while busy waits.

## Timing
- Reset (asynchronous on reset=0): state IDLE, counter 0, owner 0, latched addr 0, RR pointer = dcache-favoured. All valid/ready outputs are 0. Any in-flight transaction is abandoned; the memory side is reset together with the arbiter.
- Grant → mem_req_valid: 1 cycle, registered.
- Write-data and response steering: 0-cycle combinational passthrough.
- Minimum read transaction: 1 (grant) + 1 (REQ) + BEATS cycles. Next grant is possible in the cycle after the last beat.
- Requests arriving in the last-beat cycle are seen in the following IDLE cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On a tie, grant the requester not granted last. The pointer updates on each grant. The first tie after reset goes to the dcache.
- Undefined: fixed priority. The dcache always wins a tie. No pointer register exists.

## Test plan
- Lone icache read, addr 0x0000123, memory returns beats A0–A3 with a 2-cycle gap between beats → mem_req_addr=0x0000123, rw=0; ic_resp_valid ×4 with matching data; resp_last on A3; dc_resp_valid stays 0.
- Dcache write-back, addr 0xABCDEF0, mem_wdata_ready toggling → exactly 4 beats forwarded in order; busy drops the cycle after the 4th accept; no resp_valid.
- Both requests valid in the same cycle, back-to-back: RR_EN gives dcache, icache, dcache, icache. Without RR_EN, dcache wins every time until dc_req_valid drops.
- mem_req_ready held 0 for 10 cycles → mem_req_valid, addr and rw stay stable; no req_ready is issued to the second requester.
- Spurious mem_resp_valid while in IDLE or WDATA → no ic/dc_resp_valid.
- reset=0 asserted during RDATA beat 2 → all outputs 0 immediately. After release, a fresh icache read completes normally with counter starting at 0.
